hwag_angle_core: RTL and testbench

- Hardware angle generator for a 60-2 crank trigger wheel.
- Filters the VR capture input and measures tooth periods.
- Finds the missing-tooth gap, keeps tooth and angle sync, and interpolates a 0..3839 crank angle (64 ticks per tooth).
- Drives one ignition coil output from a fixed charge window. Sits between the VR conditioner pin and the coil driver/LEDs.

---
 rtl/hwag_angle_core.sv | 207 ++++++++++++++++++++
 tb/tb_hwag_angle_core.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hwag_angle_core.sv
// Crank angle generator for a 60-2 trigger wheel: filters VR input, syncs on the gap, interpolates angle, drives one coil.
// Latency: cap_in edge -> cap_ev 5 clocks (2 sync + filter); angle realigned 1 clock later; coil/led outputs 1 clock after that.
// Backpressure: none; free-running stream input, outputs are levels.
// Ports: clk/rst (async active-low) | cap_in raw VR input | cap_out filtered input | led1_out sync held |
//        led2_out toggles per accepted gap | coil14_out coil charge, active-high.
module hwag_angle_core #(
    parameter int FILT_LEN   = 3,
    parameter int PCNT_W     = 24,
    parameter int MIN_CAP    = 128,
    parameter int MAX_CAP    = 65535,
    parameter int TEETH_LAST = 57,
    parameter int STWD       = 4,
    parameter int ANGLE_TOP  = 3839,
    parameter int IGN_CHARGE = 1024,
    parameter int IGN_ANGLE  = 3830
) (
    input  logic clk,
    input  logic rst,
    input  logic cap_in,
    output logic cap_out,
    output logic led1_out,
    output logic led2_out,
    output logic coil14_out
);

    localparam int FC_W = $clog2(FILT_LEN + 1);
    localparam int TL_W = PCNT_W - 5;
    localparam int VC_W = $clog2(STWD + 1);
    localparam int START = (IGN_ANGLE - IGN_CHARGE + ANGLE_TOP + 1) % (ANGLE_TOP + 1);
    localparam logic [11:0] START_A = 12'(START);
    localparam logic [11:0] IGN_A   = 12'(IGN_ANGLE);
    localparam bit          WRAP    = (START > IGN_ANGLE);
    localparam logic [PCNT_W:0] STALL_LIM = (PCNT_W + 1)'(4 * MAX_CAP);

    typedef enum logic {SEARCH, SYNC} state_t;

    // ---------------- input synchronizer and glitch filter ----------------
    logic            s1, s2, cap_ev;
    logic [FC_W-1:0] fcnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1      <= 1'b0;
            s2      <= 1'b0;
            cap_out <= 1'b0;
            cap_ev  <= 1'b0;
            fcnt    <= '0;
        end else begin
            s1     <= cap_in;
            s2     <= s1;
            cap_ev <= 1'b0;
            // fcnt counts consecutive samples that disagree with cap_out
            if (s2 == cap_out) begin
                fcnt <= '0;
            end else if (fcnt == FC_W'(FILT_LEN - 1)) begin
                cap_out <= s2;
                cap_ev  <= s2;
                fcnt    <= '0;
            end else begin
                fcnt <= fcnt + FC_W'(1);
            end
        end
    end

    // ---------------- period measurement and classification ----------------
    logic [PCNT_W-1:0] pcnt;
    logic [PCNT_W:0]   period, prev_period, prev_period_n;
    logic              prev_norm, prev_norm_n;
    logic              stall, is_gap, in_rng, is_norm;
    logic [TL_W-1:0]   per_tl, new_tl;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  pcnt <= '0;
        else if (cap_ev)           pcnt <= '0;
        else if (pcnt != '1)       pcnt <= pcnt + PCNT_W'(1);
    end

    assign period  = {1'b0, pcnt} + (PCNT_W + 1)'(1);
    assign stall   = ({1'b0, pcnt} >= STALL_LIM);
    // A gap wins over the range check so a long gap never refreshes tick_len.
    assign is_gap  = prev_norm && ({1'b0, period} >= {prev_period, 1'b0});
    assign in_rng  = (period >= (PCNT_W + 1)'(MIN_CAP)) && (period <= (PCNT_W + 1)'(MAX_CAP));
    assign is_norm = in_rng && !is_gap;
    assign per_tl  = period[PCNT_W:6];
    assign new_tl  = (per_tl == '0) ? TL_W'(1) : per_tl;

    // ---------------- sync FSM and angle interpolation ----------------
    state_t          state, state_n;
    logic [VC_W-1:0] vcnt, vcnt_n;
    logic [5:0]      tooth, tooth_n, tooth_inc;
    logic [11:0]     angle, angle_n, limit;
    logic [TL_W-1:0] tick_len, tick_len_n, tick_cnt, tick_cnt_n;
    logic            led2, led2_n, tick, in_win;

    assign tooth_inc = tooth + 6'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= SEARCH;
            vcnt        <= '0;
            tooth       <= '0;
            angle       <= '0;
            tick_len    <= TL_W'(1);
            tick_cnt    <= '0;
            led2        <= 1'b0;
            prev_period <= '0;
            prev_norm   <= 1'b0;
        end else begin
            state       <= state_n;
            vcnt        <= vcnt_n;
            tooth       <= tooth_n;
            angle       <= angle_n;
            tick_len    <= tick_len_n;
            tick_cnt    <= tick_cnt_n;
            led2        <= led2_n;
            prev_period <= prev_period_n;
            prev_norm   <= prev_norm_n;
        end
    end

    always_comb begin
        state_n       = state;
        vcnt_n        = vcnt;
        tooth_n       = tooth;
        angle_n       = angle;
        tick_len_n    = tick_len;
        led2_n        = led2;
        prev_period_n = prev_period;
        prev_norm_n   = prev_norm;
        tick          = 1'b0;
        // The last real tooth may extrapolate through the two missing teeth.
        limit = (tooth == 6'(TEETH_LAST)) ? 12'(ANGLE_TOP) : {tooth, 6'h3f};

        if (tick_cnt == '0) begin
            tick       = 1'b1;
            tick_cnt_n = tick_len - TL_W'(1);
        end else begin
            tick_cnt_n = tick_cnt - TL_W'(1);
        end
        if (state == SYNC && tick && angle < limit) angle_n = angle + 12'd1;

        // Edge realignment overrides any tick in the same cycle.
        if (cap_ev) begin
            prev_period_n = period;
            prev_norm_n   = is_norm;
            if (is_norm) tick_len_n = new_tl;
            tick_cnt_n = (is_norm ? new_tl : tick_len) - TL_W'(1);
            case (state)
                SEARCH: begin
                    if (is_gap) begin
                        if (vcnt >= VC_W'(STWD)) begin
                            state_n = SYNC;
                            tooth_n = '0;
                            angle_n = '0;
                            led2_n  = ~led2;
                        end else begin
                            vcnt_n = '0;
                        end
                    end else if (is_norm) begin
                        if (vcnt < VC_W'(STWD)) vcnt_n = vcnt + VC_W'(1);
                    end else begin
                        vcnt_n = '0;
                    end
                end
                default: begin
                    if (is_gap && tooth == 6'(TEETH_LAST)) begin
                        tooth_n = '0;
                        angle_n = '0;
                        led2_n  = ~led2;
                    end else if (is_norm && tooth < 6'(TEETH_LAST)) begin
                        tooth_n = tooth_inc;
                        angle_n = {tooth_inc, 6'd0};
                    end else begin
                        state_n = SEARCH;
                        vcnt_n  = '0;
                    end
                end
            endcase
        end

        if (stall) begin
            state_n = SEARCH;
            vcnt_n  = '0;
        end
        if (state_n == SEARCH) begin
            tooth_n = '0;
            angle_n = '0;
        end
    end

    // ---------------- outputs ----------------
    assign in_win = WRAP ? ((angle >= START_A) || (angle < IGN_A))
                         : ((angle >= START_A) && (angle < IGN_A));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            led1_out   <= 1'b0;
            coil14_out <= 1'b0;
        end else begin
            led1_out   <= (state == SYNC);
            coil14_out <= (state == SYNC) && in_win;
        end
    end

    assign led2_out = led2;

endmodule

// File: tb/tb_hwag_angle_core.sv
// Bench for hwag_angle_core: two instances (default spark angle and a wrapping window) share one wheel.
// Latency: checks sample on the falling clock edge, well away from output transitions.
// Backpressure: none.
module tb_hwag_angle_core;

    localparam int MINC  = 100;
    localparam int MAXC  = 1023;
    localparam int STALL = 4 * MAXC;
    localparam int CHG   = 1024;
    localparam int TOP   = 3839;
    localparam int IGN_A = 3830;
    localparam int IGN_B = 100;

    logic clk = 1'b0;
    logic rst;
    logic cap_in;
    logic a_cap, a_led1, a_led2, a_coil;
    logic b_cap, b_led1, b_led2, b_coil;

    always #5 clk = ~clk;

    hwag_angle_core #(.MIN_CAP(MINC), .MAX_CAP(MAXC)) dut_a (
        .clk(clk), .rst(rst), .cap_in(cap_in), .cap_out(a_cap),
        .led1_out(a_led1), .led2_out(a_led2), .coil14_out(a_coil));

    hwag_angle_core #(.MIN_CAP(MINC), .MAX_CAP(MAXC), .IGN_ANGLE(IGN_B)) dut_b (
        .clk(clk), .rst(rst), .cap_in(cap_in), .cap_out(b_cap),
        .led1_out(b_led1), .led2_out(b_led2), .coil14_out(b_coil));

    int total = 0;
    int bad   = 0;

    // edge-level reference model of the wheel decoder
    bit m_sync, m_led2, m_prev_norm;
    int m_cnt, m_tooth, m_prev, m_tl, next_p, ecount;

    task automatic chk(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic bit in_win(input int a, input int ign);
        int st;
        st = (ign - CHG + TOP + 1) % (TOP + 1);
        if (st <= ign) return (a >= st) && (a < ign);
        return (a >= st) || (a < ign);
    endfunction

    // Angle o clocks after the edge was driven: 6 clocks of input/filter/realign latency,
    // then one tick every m_tl clocks, clamped at the tooth's limit.
    function automatic int ang(input int o);
        int base, lim, a;
        base = m_tooth * 64;
        lim  = (m_tooth == 57) ? TOP : base + 63;
        a    = base + (o - 6) / m_tl;
        return (a > lim) ? lim : a;
    endfunction

    // Expected coil level, valid only when the window state is the same a few clocks either side.
    function automatic bit stable(input int o, input int ign, output bit w);
        w = in_win(ang(o - 1), ign);
        for (int k = -3; k <= 1; k++)
            if (in_win(ang(o + k), ign) != w) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input int p);
        bit gap, nv;
        gap = m_prev_norm && (p >= 2 * m_prev);
        nv  = !gap && (p >= MINC) && (p <= MAXC);
        if (!m_sync) begin
            if (gap) begin
                if (m_cnt >= 4) begin
                    m_sync  = 1'b1;
                    m_tooth = 0;
                    m_led2  = !m_led2;
                end else begin
                    m_cnt = 0;
                end
            end else if (nv) begin
                m_cnt = (m_cnt < 4) ? m_cnt + 1 : 4;
            end else begin
                m_cnt = 0;
            end
        end else if (gap && m_tooth == 57) begin
            m_tooth = 0;
            m_led2  = !m_led2;
        end else if (nv && m_tooth < 57) begin
            m_tooth++;
        end else begin
            m_sync = 1'b0;
            m_cnt  = 0;
        end
        if (nv) m_tl = (p / 64 < 1) ? 1 : p / 64;
        m_prev      = p;
        m_prev_norm = nv;
    endtask

    task automatic checks(input int o, input int per);
        bit s, w;
        if (per > STALL && o >= STALL - 20 && o <= STALL + 30) return;
        s = (per > STALL && o > STALL) ? 1'b0 : m_sync;
        chk($sformatf("led1a e%0d o%0d", ecount, o), a_led1, s);
        chk($sformatf("led1b e%0d o%0d", ecount, o), b_led1, s);
        chk($sformatf("led2a e%0d o%0d", ecount, o), a_led2, m_led2);
        if (!s) begin
            chk($sformatf("coila e%0d o%0d", ecount, o), a_coil, 1'b0);
            chk($sformatf("coilb e%0d o%0d", ecount, o), b_coil, 1'b0);
        end else begin
            if (stable(o, IGN_A, w)) chk($sformatf("coila e%0d o%0d", ecount, o), a_coil, w);
            if (stable(o, IGN_B, w)) chk($sformatf("coilb e%0d o%0d", ecount, o), b_coil, w);
        end
    endtask

    // One rising edge of the wheel, followed by `per` clocks until the next edge.
    task automatic step(input int per);
        int hi;
        model_edge(next_p);
        ecount++;
        hi = $urandom_range(10, 60);
        cap_in = 1'b1;
        for (int o = 1; o <= per; o++) begin
            @(negedge clk);
            if (o == hi) cap_in = 1'b0;
            if (o % 40 == 20) checks(o, per);
        end
        if (per > STALL) begin
            m_sync = 1'b0;
            m_cnt  = 0;
        end
        next_p = per;
    endtask

    function automatic int np();
        return $urandom_range(130, 180);
    endfunction

    function automatic int gp();
        return $urandom_range(400, 540);
    endfunction

    initial begin
        rst    = 1'b1;
        cap_in = 1'b0;
        #2 rst = 1'b0;

        // reset held while the input toggles
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cap_in = i[0];
            if (i >= 4) begin
                chk("rst cap", a_cap, 1'b0);
                chk("rst led1", a_led1, 1'b0);
                chk("rst led2", a_led2, 1'b0);
                chk("rst coil", a_coil, 1'b0);
            end
        end
        @(negedge clk);
        cap_in = 1'b0;
        rst    = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle cap", a_cap, 1'b0);
        chk("idle led1", a_led1, 1'b0);
        chk("idle led2", b_led2, 1'b0);
        chk("idle coil", b_coil, 1'b0);

        // 2-clock glitch is swallowed by the filter
        cap_in = 1'b1;
        repeat (2) @(negedge clk);
        cap_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("glitch %0d", i), a_cap, 1'b0);
        end

        // held level appears after exactly 2 + FILT_LEN clocks
        cap_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("rise early", a_cap, 1'b0);
        @(negedge clk);
        chk("rise", a_cap, 1'b1);
        chk("rise b", b_cap, 1'b1);
        repeat (10) @(negedge clk);
        cap_in = 1'b0;
        repeat (4) @(negedge clk);
        chk("fall early", a_cap, 1'b1);
        @(negedge clk);
        chk("fall", a_cap, 1'b0);

        // let the period counter stall so the wheel starts from a clean search
        repeat (5000) @(negedge clk);
        m_sync = 1'b0; m_led2 = 1'b0; m_prev_norm = 1'b0;
        m_cnt = 0; m_tooth = 0; m_prev = 0; m_tl = 1;
        next_p = 1 << 20;
        ecount = 0;

        // teeth 55, 56, 57, early gap rejected, then three revolutions
        step(np()); step(np()); step(gp());
        repeat (3) begin
            repeat (57) step(np());
            step(gp());
        end

        // stop the wheel at tooth 10: sync lost after the stall time
        repeat (10) step(np());
        step(STALL + 300);

        // re-sync, then an extra tooth inside the gap drops sync, then re-sync again
        repeat (6) step(np());
        step(gp());
        repeat (57) step(np());
        step($urandom_range(200, 250));
        repeat (6) step(np());
        step(gp());
        repeat (5) step(np());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
